// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 inverse cipher: one round per clock over a 128-bit state
// register, with round keys fetched from a synchronous-read key-schedule RAM.
module aes_dec_round_ctrl #(
   parameter int NR    = 10,
   parameter int RK_AW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             rk_rd_en,
   output logic [RK_AW-1:0] rk_addr,
   input  logic [127:0]     rk_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } fsm_e;

   localparam logic [RK_AW-1:0] RK_NR  = RK_AW'(NR);
   localparam logic [RK_AW-1:0] RK_NR1 = RK_AW'(NR - 1);
   localparam logic [RK_AW-1:0] RK_NR2 = RK_AW'(NR - 2);
   localparam logic [RK_AW-1:0] RK_ONE = RK_AW'(1);
   localparam logic [RK_AW-1:0] RK_TWO = RK_AW'(2);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a;
      a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   // Byte k sits at bits [127-8k -: 8]; byte 4c+r is row r of column c.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         o[8*(15-k) +: 8] = inv_sbox(s[8*(15-k) +: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(15-4*c)   +: 8];
         a1 = s[8*(14-4*c)   +: 8];
         a2 = s[8*(13-4*c)   +: 8];
         a3 = s[8*(12-4*c)   +: 8];
         o[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   fsm_e             fsm_q, fsm_d;
   logic [127:0]     blk_q, blk_d;
   logic [RK_AW-1:0] cnt_q, cnt_d;
   logic [RK_AW-1:0] rk_addr_q, rk_addr_d;
   logic             rk_rd_en_q, rk_rd_en_d;
   logic             out_valid_q, out_valid_d;
   logic [127:0]     out_data_q, out_data_d;

   logic [127:0]     dec_core;
   logic [127:0]     round_last;
   logic [127:0]     round_mid;

   assign dec_core   = inv_sub_bytes(inv_shift_rows(blk_q));
   assign round_last = dec_core ^ rk_data;
   assign round_mid  = inv_mix_columns(round_last);

   always_comb begin
      fsm_d       = fsm_q;
      blk_d       = blk_q;
      cnt_d       = cnt_q;
      rk_addr_d   = rk_addr_q;
      rk_rd_en_d  = rk_rd_en_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               blk_d      = in_data;
               rk_addr_d  = RK_NR;
               rk_rd_en_d = 1'b1;
               fsm_d      = S_PRIME;
            end
         end
         S_PRIME: begin
            rk_addr_d = RK_NR1;
            fsm_d     = S_INIT;
         end
         S_INIT: begin
            blk_d     = blk_q ^ rk_data;
            rk_addr_d = RK_NR2;
            cnt_d     = RK_NR1;
            fsm_d     = S_ROUND;
         end
         S_ROUND: begin
            blk_d = round_mid;
            // Address 0 was presented this cycle; its key arrives in FINAL.
            if (cnt_q == RK_ONE) begin
               cnt_d      = '0;
               rk_rd_en_d = 1'b0;
               fsm_d      = S_FINAL;
            end else begin
               cnt_d     = cnt_q - RK_ONE;
               rk_addr_d = cnt_q - RK_TWO;
            end
         end
         S_FINAL: begin
            blk_d       = round_last;
            out_data_d  = round_last;
            out_valid_d = 1'b1;
            rk_rd_en_d  = 1'b0;
            fsm_d       = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         blk_q       <= '0;
         cnt_q       <= '0;
         rk_addr_q   <= '0;
         rk_rd_en_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         fsm_q       <= fsm_d;
         blk_q       <= blk_d;
         cnt_q       <= cnt_d;
         rk_addr_q   <= rk_addr_d;
         rk_rd_en_q  <= rk_rd_en_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = (fsm_q == S_IDLE);
   assign busy      = (fsm_q != S_IDLE);
   assign rk_addr   = rk_addr_q;
   assign rk_rd_en  = rk_rd_en_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
